// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if -- two-port word request bus between the port masters and mem_ctrl.
// Per-port fields are packed side by side, port p in the slice noted below.
//   mem_rwe_i  [2p+1:2p]    op: 01 read, 10 write, 00/11 idle   (master -> slave)
//   mem_addr_i [32p+31:32p] byte address                        (master -> slave)
//   mem_sel_i  [4p+3:4p]    write byte enables                  (master -> slave)
//   mem_data_i [32p+31:32p] write data                          (master -> slave)
//   mem_data_o [32p+31:32p] last read data                      (slave -> master)
//   mem_busy_o [p]          transfer in progress                (slave -> master)
//   mem_done_o [p]          one-cycle completion pulse          (slave -> master)
interface mem_ctrl_if;
  logic [3:0]  mem_rwe_i;
  logic [63:0] mem_addr_i;
  logic [7:0]  mem_sel_i;
  logic [63:0] mem_data_i;
  logic [63:0] mem_data_o;
  logic [1:0]  mem_busy_o;
  logic [1:0]  mem_done_o;

  modport master (
    output mem_rwe_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_busy_o, mem_done_o
  );

  modport slave (
    input  mem_rwe_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_busy_o, mem_done_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl -- serves 32-bit word reads/writes from two ports onto a byte-wide
// synchronous RAM, one byte per cycle (ISSUE k=0..3, FINISH, DONE).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus            mem_ctrl_if.slave, the two request ports
//   ram_addr_o     byte RAM address (holds last value outside ISSUE)
//   ram_we_o       byte RAM write strobe
//   ram_data_o     byte RAM write data (holds last value outside ISSUE)
//   ram_data_i     byte RAM read data, valid one cycle after its address
// Configuration: define MEM_CTRL_RR_EN for round-robin arbitration; the
// default build uses fixed priority with port 0 winning conflicts.
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_ctrl_if.slave                 bus,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_we_o,
  output logic [7:0]                ram_data_o,
  input  logic [7:0]                ram_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FINISH, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                k_q, k_d;
  logic                      wr_q, wr_d;
  logic [RAM_ADDR_WIDTH-3:0] base_q, base_d;
  logic [3:0]                sel_q, sel_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      g_q, g_d;
  logic [31:0]               rbuf_q, rbuf_d;
  logic [1:0][31:0]          mem_data_q, mem_data_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]                ram_data_q, ram_data_d;

  logic [1:0]  req;
  logic        grant;
  logic        accept;
  logic [63:0] mem_data_out;
  logic [1:0]  busy_out;
  logic [1:0]  done_out;

  // Op 01 and 10 are requests; 00 and 11 are both idle.
  assign req[0] = bus.mem_rwe_i[1] ^ bus.mem_rwe_i[0];
  assign req[1] = bus.mem_rwe_i[3] ^ bus.mem_rwe_i[2];
  assign accept = (state_q == S_IDLE) && (|req);

`ifdef MEM_CTRL_RR_EN
  // prio_q names the port that wins the next conflict.
  logic prio_q, prio_d;
  assign grant  = (req == 2'b11) ? prio_q : req[1];
  assign prio_d = accept ? ~grant : prio_q;

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`else
  assign grant = ~req[0];
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          k_d     = 2'd0;
        end
      end
      S_ISSUE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ram_we_o     = 1'b0;
    ram_addr_o   = ram_addr_q;
    ram_data_o   = ram_data_q;
    busy_out     = 2'b00;
    done_out     = 2'b00;
    mem_data_out = mem_data_q;
    unique case (state_q)
      S_ISSUE: begin
        busy_out   = 2'b11;
        // Word-aligned base plus byte counter; addr[1:0] is discarded.
        ram_addr_o = {base_q, k_q};
        if (wr_q) begin
          ram_we_o   = sel_q[k_q];
          ram_data_o = wdata_q[8*k_q +: 8];
        end
      end
      S_FINISH: busy_out = 2'b11;
      S_DONE: begin
        done_out[g_q] = 1'b1;
        // Read data is visible in the same cycle as the done pulse.
        if (!wr_q) mem_data_out[32*g_q +: 32] = rbuf_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_data_o = mem_data_out;
  assign bus.mem_busy_o = busy_out;
  assign bus.mem_done_o = done_out;

  // Datapath: request latch, read byte capture, per-port read data.
  always_comb begin
    wr_d       = wr_q;
    base_d     = base_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    g_d        = g_q;
    rbuf_d     = rbuf_q;
    mem_data_d = mem_data_q;
    ram_addr_d = ram_addr_o;
    ram_data_d = ram_data_o;
    if (accept) begin
      g_d     = grant;
      wr_d    = bus.mem_rwe_i[2*grant+1];
      base_d  = bus.mem_addr_i[32*grant+2 +: RAM_ADDR_WIDTH-2];
      sel_d   = bus.mem_sel_i[4*grant +: 4];
      wdata_d = bus.mem_data_i[32*grant +: 32];
    end
    // RAM read data lags its address by one cycle, so ISSUE k holds byte k-1.
    if (state_q == S_ISSUE && !wr_q && k_q != 2'd0)
      rbuf_d[8*(int'(k_q)-1) +: 8] = ram_data_i;
    if (state_q == S_FINISH && !wr_q)
      rbuf_d[31:24] = ram_data_i;
    if (state_q == S_DONE && !wr_q)
      mem_data_d[g_q] = rbuf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      base_q     <= '0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      g_q        <= 1'b0;
      rbuf_q     <= 32'd0;
      mem_data_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= 8'd0;
    end else begin
      wr_q       <= wr_d;
      base_q     <= base_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      g_q        <= g_d;
      rbuf_q     <= rbuf_d;
      mem_data_q <= mem_data_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- directed stimulus for mem_ctrl with a transaction-level
// reference model compared against the DUT every cycle, plus hand-computed
// literal expectations for the headline scenarios.
module tb_mem_ctrl;
  localparam int AW = 17;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata)
  );

  // Byte RAM driven by the DUT, read data registered one cycle.
  logic [7:0] ram     [0:(1<<AW)-1];
  logic [7:0] exp_ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: phase counts cycles since the accepting edge (0 = idle).
  // Cycles 1..4 move bytes 0..3, cycle 5 finishes, cycle 6 is the done cycle.
  int          phase   = 0;
  bit          model_on = 0;
  bit          m_wr;
  bit          m_g;
  logic [31:0] m_addr;
  logic [3:0]  m_sel;
  logic [31:0] m_data;
  logic [63:0] exp_data = '0;
  bit          prio = 0;

  always @(posedge clk) begin
    bit r0, r1, g;
    logic [AW-1:0] base;
    if (phase >= 1 && phase <= 4 && m_wr && m_sel[phase-1])
      exp_ram[{m_addr[AW-1:2], 2'(phase-1)}] = m_data[8*(phase-1) +: 8];
    r0 = (bus.mem_rwe_i[1:0] == OP_RD) || (bus.mem_rwe_i[1:0] == OP_WR);
    r1 = (bus.mem_rwe_i[3:2] == OP_RD) || (bus.mem_rwe_i[3:2] == OP_WR);
    if (rst) begin
      phase    = 0;
      exp_data = '0;
      prio     = 0;
      model_on = 1;
    end else if (phase == 0) begin
      if (r0 || r1) begin
`ifdef MEM_CTRL_RR_EN
        g = (r0 && r1) ? prio : r1;
`else
        g = !r0;
`endif
        prio   = !g;
        m_g    = g;
        m_wr   = (bus.mem_rwe_i[2*g +: 2] == OP_WR);
        m_addr = bus.mem_addr_i[32*g +: 32];
        m_sel  = bus.mem_sel_i[4*g +: 4];
        m_data = bus.mem_data_i[32*g +: 32];
        phase  = 1;
      end
    end else if (phase == 5) begin
      phase = 6;
      if (!m_wr) begin
        base = {m_addr[AW-1:2], 2'b00};
        exp_data[32*m_g +: 32] = {exp_ram[base+3], exp_ram[base+2],
                                  exp_ram[base+1], exp_ram[base]};
      end
    end else if (phase == 6) begin
      phase = 0;
    end else begin
      phase++;
    end
  end

  // Single compare process, sampled away from the active edge.
  int we_cnt = 0;
  always @(negedge clk) begin
    logic [1:0] exp_busy, exp_done;
    logic exp_we;
    if (ram_we === 1'b1) we_cnt++;
    if (model_on) begin
      exp_busy = (phase >= 1 && phase <= 5) ? 2'b11 : 2'b00;
      exp_done = (phase == 6) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      exp_we   = (phase >= 1 && phase <= 4) ? (m_wr && m_sel[phase-1]) : 1'b0;
      check("busy", 64'(bus.mem_busy_o), 64'(exp_busy));
      check("done", 64'(bus.mem_done_o), 64'(exp_done));
      check("mem_data_o", bus.mem_data_o, exp_data);
      check("ram_we", 64'(ram_we), 64'(exp_we));
      if (phase >= 1 && phase <= 4)
        check("ram_addr", 64'(ram_addr), 64'({m_addr[AW-1:2], 2'(phase-1)}));
      if (exp_we)
        check("ram_wdata", 64'(ram_wdata), 64'(m_data[8*(phase-1) +: 8]));
    end
  end

  task automatic drive(input int p, input logic [1:0] op, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data);
    bus.mem_rwe_i[2*p +: 2]   = op;
    bus.mem_addr_i[32*p +: 32] = addr;
    bus.mem_sel_i[4*p +: 4]   = sel;
    bus.mem_data_i[32*p +: 32] = data;
  endtask

  // Counts rising edges from the call until done[p] is seen; bounded.
  task automatic wait_done(input int p, output int lat, output bit ok);
    lat = 0;
    ok  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.mem_done_o[p]) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int lat;
  bit ok;
  int grants [4];
  int exp_grants [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i]     = 8'h00;
      exp_ram[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      ram[17'h100 + i]     = 8'(8'h11 * (i + 1));
      exp_ram[17'h100 + i] = 8'(8'h11 * (i + 1));
      ram[17'h200 + i]     = 8'(i + 1);
      exp_ram[17'h200 + i] = 8'(i + 1);
    end
    bus.mem_rwe_i  = '0;
    bus.mem_addr_i = '0;
    bus.mem_sel_i  = '0;
    bus.mem_data_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.mem_busy_o), 64'd0);
    check("rst_done", 64'(bus.mem_done_o), 64'd0);
    check("rst_data", bus.mem_data_o, 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    rst = 1'b0;
    next_cycle();

    // Port 1 word read at 0x102 returns the aligned word at 0x100
    drive(1, OP_RD, 32'h0000_0102, 4'h0, 32'h0);
    wait_done(1, lat, ok);
    check("rd1_done_seen", 64'(ok), 64'd1);
    check("rd1_latency", 64'(lat), 64'd6);
    check("rd1_data", 64'(bus.mem_data_o[63:32]), 64'h4433_2211);
    drive(1, 2'b00, 32'h0, 4'h0, 32'h0);

    // Port 0 partial write: only bytes 0 and 2 strobed
    next_cycle();
    we_cnt = 0;
    drive(0, OP_WR, 32'h0000_0200, 4'b0101, 32'hAABB_CCDD);
    wait_done(0, lat, ok);
    check("wr_done_seen", 64'(ok), 64'd1);
    check("wr_latency", 64'(lat), 64'd6);
    check("wr_we_pulses", 64'(we_cnt), 64'd2);
    check("wr_keeps_data1", 64'(bus.mem_data_o[63:32]), 64'h4433_2211);
    drive(0, 2'b00, 32'h0, 4'h0, 32'h0);

    next_cycle();
    drive(0, OP_RD, 32'h0000_0201, 4'h0, 32'h0);
    wait_done(0, lat, ok);
    check("rdback_done_seen", 64'(ok), 64'd1);
    check("rdback_data", 64'(bus.mem_data_o[31:0]), 64'h04BB_02DD);
    drive(0, 2'b00, 32'h0, 4'h0, 32'h0);

    // Write with no byte enables: no strobes, done still pulses
    next_cycle();
    we_cnt = 0;
    drive(0, OP_WR, 32'h0000_0200, 4'b0000, 32'h1234_5678);
    wait_done(0, lat, ok);
    check("sel0_done_seen", 64'(ok), 64'd1);
    check("sel0_latency", 64'(lat), 64'd6);
    check("sel0_we_pulses", 64'(we_cnt), 64'd0);
    check("sel0_data_kept", 64'(bus.mem_data_o[31:0]), 64'h04BB_02DD);
    drive(0, 2'b00, 32'h0, 4'h0, 32'h0);

    // Reset clears the arbitration pointer before the conflict test
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // Both ports read continuously
`ifdef MEM_CTRL_RR_EN
    exp_grants = '{0, 1, 0, 1};
`else
    exp_grants = '{0, 0, 0, 1};
`endif
    drive(0, OP_RD, 32'h0000_0100, 4'h0, 32'h0);
    drive(1, OP_RD, 32'h0000_0200, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      grants[i] = -1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.mem_done_o == 2'b01) begin grants[i] = 0; break; end
        if (bus.mem_done_o == 2'b10) begin grants[i] = 1; break; end
      end
`ifndef MEM_CTRL_RR_EN
      if (i == 2) drive(0, 2'b00, 32'h0, 4'h0, 32'h0);
`endif
      check($sformatf("grant_%0d", i), 64'(grants[i]), 64'(exp_grants[i]));
    end
    drive(0, 2'b00, 32'h0, 4'h0, 32'h0);
    drive(1, 2'b00, 32'h0, 4'h0, 32'h0);

    // Reset during ISSUE k=2 of a write, request held through reset
    next_cycle();
    we_cnt = 0;
    drive(0, OP_WR, 32'h0000_0300, 4'b1111, 32'h5566_7788);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("abort_busy", 64'(bus.mem_busy_o), 64'd0);
    check("abort_done", 64'(bus.mem_done_o), 64'd0);
    check("abort_data", bus.mem_data_o, 64'd0);
    check("abort_we_pulses", 64'(we_cnt), 64'd3);
    wait_done(0, lat, ok);
    check("rearm_done_seen", 64'(ok), 64'd1);
    check("rearm_latency", 64'(lat), 64'd6);
    drive(0, 2'b00, 32'h0, 4'h0, 32'h0);

    next_cycle();
    drive(1, OP_RD, 32'h0000_0300, 4'h0, 32'h0);
    wait_done(1, lat, ok);
    check("rd300_done_seen", 64'(ok), 64'd1);
    check("rd300_data", 64'(bus.mem_data_o[63:32]), 64'h5566_7788);
    drive(1, 2'b00, 32'h0, 4'h0, 32'h0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 17: width of the byte RAM address; port addresses are truncated to their low RAM_ADDR_WIDTH bits.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_rwe_i  input  4  per-port op; [2p+1:2p] for port p; 2'b01 read, 2'b10 write, 2'b00 and 2'b11 idle.
REQ-005 mem_addr_i  input  64  per-port byte address; [32p+31:32p].
REQ-006 mem_sel_i  input  8  per-port write byte enables; [4p+3:4p].
REQ-007 mem_data_i  input  64  per-port write data; [32p+31:32p].
REQ-008 mem_data_o  output  64  per-port read data; [32p+31:32p].
REQ-009 mem_busy_o  output  2  per-port busy.
REQ-010 mem_done_o  output  2  per-port completion pulse.
REQ-011 ram_addr_o  output  RAM_ADDR_WIDTH  byte RAM address.
REQ-012 ram_we_o  output  1  byte RAM write strobe.
REQ-013 ram_data_o  output  8  byte RAM write data.
REQ-014 ram_data_i  input  8  byte RAM read data, valid one cycle after its address is presented.

Function
REQ-015 States: IDLE, ISSUE (byte counter k = 0..3), FINISH, DONE.
REQ-016 In IDLE, the block samples both ports each cycle; a port with op 01 or 10 is a requester.
REQ-017 On acceptance, the block latches op, addr, sel, write data and port index g, then enters ISSUE with k=0.
REQ-018 Arbitration: with both ports requesting, port 0 wins (fixed priority, unless REQ-035 applies).
REQ-019 In ISSUE k, ram_addr_o = {addr[RAM_ADDR_WIDTH-1:2], k[1:0]}, i.e. a word-aligned base plus k; addr[1:0] is ignored.
REQ-020 Write in ISSUE k: ram_we_o = sel[k], ram_data_o = data[8k+7:8k].
REQ-021 Read in ISSUE k: ram_we_o = 0; ram_data_i is captured into byte k-1 of the read buffer when k > 0; all 4 bytes are read regardless of sel.
REQ-022 After ISSUE k=3 the block enters FINISH for one cycle; a read captures byte 3 there; ram_we_o = 0.
REQ-023 DONE lasts one cycle: mem_done_o[g] = 1 and the other done bit = 0; a read updates mem_data_o[g] with the buffer in that same cycle; then IDLE.
REQ-024 Latency: done is asserted 6 cycles after the accepting edge, for both read and write.
REQ-025 No request is sampled in DONE; the same port can be accepted again at the earliest one cycle after its done pulse.
REQ-026 mem_data_o[p] holds its value until port p's next read completion; writes leave it unchanged.
REQ-027 mem_busy_o[p] = 1 in ISSUE and FINISH for both ports; it is 0 in IDLE and DONE.
REQ-028 A losing port keeps its request asserted and is accepted on the first IDLE cycle in which it wins arbitration.
REQ-029 A write with sel = 4'b0000 walks all states with no ram_we_o pulse and still pulses done.
REQ-030 Port input changes after acceptance do not affect the transfer in progress.
REQ-031 Outside ISSUE, ram_we_o = 0 and ram_addr_o/ram_data_o hold their last values.

Reset
REQ-032 When rst is high at a rising edge, the block enters IDLE and the outputs become: mem_done_o = 0, mem_busy_o = 0, mem_data_o = 0, ram_we_o = 0, ram_addr_o = 0, ram_data_o = 0; the arbitration pointer is cleared to favour port 0.
REQ-033 Reset mid-transfer abandons the transfer; no done pulse is produced and no further ram_we_o pulse occurs.
REQ-034 A request held through reset deassertion is accepted in the first IDLE cycle after reset.

Configuration
REQ-035 Macro MEM_CTRL_RR_EN defined: round-robin arbitration; after serving port g, a simultaneous request is granted to port 1-g; a single requester always wins.
REQ-036 MEM_CTRL_RR_EN undefined: fixed priority, port 0 always wins a conflict; no pointer register is implemented.

Verification
REQ-037 RAM preloaded 0x100..0x103 = 11,22,33,44; port 1 read 0x102 -> done[1] 6 cycles after acceptance, mem_data_o[63:32] = 0x44332211.
REQ-038 Port 0 write 0x200, data 0xAABBCCDD, sel 4'b0101 -> ram_we_o pulses only for bytes 0x200 (DD) and 0x202 (BB); a later read returns 0xXXBBXXDD with old bytes preserved.
REQ-039 Both ports read simultaneously, held continuously -> fixed priority: port 0 is served repeatedly while port 1 starves until port 0 drops its request; RR: grants alternate 0,1,0,1.
REQ-040 rst asserted during ISSUE k=2 of a write -> no further ram_we_o pulse, no done pulse, busy = 0 the next cycle; the held request is accepted after reset.
REQ-041 Write with sel = 0 -> zero ram_we_o pulses, done pulses at cycle 6, mem_data_o unchanged.
